// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Packet-granular round-robin arbiter sharing one UART byte port,
//            with a mid-packet stall watchdog.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       abort
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_grant;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_CNT_W-1:0]   r_stall;
    logic                 r_abort;

    logic [c_IDX_W-1:0]   w_cand;
    logic [c_IDX_W-1:0]   w_pick;
    logic                 w_any;
    logic [c_IDX_W-1:0]   w_next_ptr;
    logic                 w_lock;
    logic                 w_owner_valid;
    logic                 w_owner_last;
    logic                 w_xfer;
    logic                 w_timeout;

    // Scan downward so the candidate closest to r_rr_ptr is written last and wins.
    always_comb begin
        w_cand = '0;
        w_pick = r_rr_ptr;
        w_any  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    assign w_next_ptr    = (r_grant == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    // Outputs are forced quiet while reset is held, even if the state is still LOCK.
    assign w_lock        = (r_state == S_LOCK) && !rst;
    assign w_owner_valid = req_valid[r_grant];
    assign w_owner_last  = req_last[r_grant];
    assign tx_valid      = w_lock && w_owner_valid;
    assign tx_data       = req_data[{r_grant, 3'b000} +: 8];
    assign w_xfer        = tx_valid && tx_ready;
    assign w_timeout     = (TIMEOUT != 0) && w_lock && !w_owner_valid && (r_stall == c_CNT_LAST);

    always_comb begin
        req_ready = '0;
        if (w_lock) begin
            req_ready[r_grant] = tx_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_stall  <= '0;
            r_abort  <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_stall <= '0;
                        r_state <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (w_xfer && w_owner_last) begin
                        r_state  <= S_IDLE;
                        r_rr_ptr <= w_next_ptr;
                        r_stall  <= '0;
                    end else if (w_xfer) begin
                        r_stall <= '0;
                    end else if (w_timeout) begin
                        r_abort  <= 1'b1;
                        r_state  <= S_IDLE;
                        r_rr_ptr <= w_next_ptr;
                        r_stall  <= '0;
                    end else if (!w_owner_valid && (TIMEOUT != 0)) begin
                        r_stall <= r_stall + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant_id = r_grant;
    assign busy     = (r_state == S_LOCK);
    assign abort    = r_abort;

endmodule
`default_nettype wire
